// File: rtl/ws2812b_decoder.sv
// WS2812B serial line decoder: classifies synchronised high-pulse widths into bits,
// assembles 24-bit GRB words MSB first, and reports pixels, frame latches and errors.
module ws2812b_decoder #(
  parameter int ONE_THRESHOLD = 8,
  parameter int MIN_HIGH      = 2,
  parameter int MAX_HIGH      = 14,
  parameter int RESET_CYCLES  = 600,
  parameter int INDEX_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   din,
  output logic [23:0]            pixel_data,
  output logic                   pixel_valid,
  output logic [INDEX_WIDTH-1:0] pixel_index,
  output logic                   frame_done,
  output logic                   error
);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam int HIGH_W = $clog2(MAX_HIGH + 2);
  localparam int LOW_W  = $clog2(RESET_CYCLES + 1);

  localparam logic [HIGH_W-1:0] HIGH_SAT = HIGH_W'(MAX_HIGH + 1);
  localparam logic [HIGH_W-1:0] HIGH_MIN = HIGH_W'(MIN_HIGH);
  localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH);
  localparam logic [HIGH_W-1:0] HIGH_ONE = HIGH_W'(ONE_THRESHOLD);
  localparam logic [LOW_W-1:0]  LOW_SAT  = LOW_W'(RESET_CYCLES);

  logic                   meta_q, meta_d;
  logic                   ds_q, ds_d;
  logic [HIGH_W-1:0]      high_cnt_q, high_cnt_d;
  logic [LOW_W-1:0]       low_cnt_q, low_cnt_d;
  state_t                 state_q, state_d;
  logic [22:0]            shift_q, shift_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [23:0]            pixel_data_q, pixel_data_d;
  logic                   pixel_valid_q, pixel_valid_d;
  logic [INDEX_WIDTH-1:0] pixel_index_q, pixel_index_d;
  logic                   frame_done_q, frame_done_d;
  logic                   error_q, error_d;
  logic                   inc_pending_q, inc_pending_d;
  logic                   pix_seen_q, pix_seen_d;

  logic                   new_bit;
  logic [23:0]            word;

  // Pulse classification happens on the cycle the synchronised line is seen low
  // again, so high_cnt_q then holds the full high width of the pulse just ended.
  always_comb begin
    meta_d        = din;
    ds_d          = meta_q;
    high_cnt_d    = '0;
    low_cnt_d     = '0;
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    error_d       = 1'b0;
    inc_pending_d = 1'b0;
    pix_seen_d    = pix_seen_q;
    pixel_index_d = inc_pending_q ? pixel_index_q + INDEX_WIDTH'(1) : pixel_index_q;
    new_bit       = (high_cnt_q >= HIGH_ONE);
    word          = {shift_q, new_bit};

    if (ds_q) begin
      high_cnt_d = (high_cnt_q == HIGH_SAT) ? HIGH_SAT : high_cnt_q + HIGH_W'(1);
    end else begin
      low_cnt_d = (low_cnt_q == LOW_SAT) ? LOW_SAT : low_cnt_q + LOW_W'(1);
    end

    case (state_q)
      SYNC: begin
        if (low_cnt_q == LOW_SAT) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (ds_q) begin
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (ds_q) begin
          if (high_cnt_q >= HIGH_MAX) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = SYNC;
          end
        end else if ((high_cnt_q < HIGH_MIN) || (high_cnt_q > HIGH_MAX)) begin
          error_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = SYNC;
        end else begin
          shift_d = word[22:0];
          state_d = LOW;
          if (bit_cnt_q == 5'd23) begin
            pixel_data_d  = word;
            pixel_valid_d = 1'b1;
            bit_cnt_d     = '0;
            inc_pending_d = 1'b1;
            pix_seen_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      LOW: begin
        // A latch with a partial word is reported as an error instead of a frame.
        if (low_cnt_q == LOW_SAT) begin
          if (bit_cnt_q != 5'd0) begin
            error_d = 1'b1;
          end else if (pix_seen_q) begin
            frame_done_d = 1'b1;
          end
          bit_cnt_d     = '0;
          pixel_index_d = '0;
          pix_seen_d    = 1'b0;
          state_d       = ds_q ? HIGH : IDLE;
        end else if (ds_q) begin
          state_d = HIGH;
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q        <= 1'b0;
      ds_q          <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      state_q       <= SYNC;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
      inc_pending_q <= 1'b0;
      pix_seen_q    <= 1'b0;
    end else begin
      meta_q        <= meta_d;
      ds_q          <= ds_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
      inc_pending_q <= inc_pending_d;
      pix_seen_q    <= pix_seen_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign error       = error_q;

endmodule
